// File: rtl/debayer_pkg.sv
// rtl/debayer_pkg.sv - shared types and default widths for the Bayer quad demosaic
package debayer_pkg;

   localparam int PIXEL_W_DEF    = 10;
   localparam int HSIZE_MAX_DEF  = 1288;
   localparam int X_W_DEF        = 11;
   localparam int Y_W_DEF        = 10;
   localparam int FIFO_DEPTH_DEF = 8;

   typedef enum logic [1:0] {
      RGGB = 2'd0,
      GRBG = 2'd1,
      GBRG = 2'd2,
      BGGR = 2'd3
   } bayer_pattern_e;

   typedef struct packed {
      logic [PIXEL_W_DEF-1:0] r;
      logic [PIXEL_W_DEF-1:0] g;
      logic [PIXEL_W_DEF-1:0] b;
   } rgb_t;

endpackage

// File: rtl/debayer_out_fifo.sv
// rtl/debayer_out_fifo.sv - synchronous show-ahead FIFO with registered read data
module debayer_out_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_n;
   logic [AW:0]      count;
   logic             push;
   logic             pop;
   logic             head_from_wr;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign pop   = rd_en & ~empty;
   // A write into a full FIFO is accepted when the head leaves in the same cycle.
   assign push  = wr_en & (~full | pop);
   assign rd_ptr_n = rd_ptr + AW'(pop);
   // The incoming word becomes the head when nothing else remains queued.
   assign head_from_wr = push & (count == (AW+1)'(pop));

   // Storage array, written at the tail pointer.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Pointer/occupancy bookkeeping and the registered head word.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr_n;
         count  <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (head_from_wr)
            rd_data <= wr_data;
         else if (pop)
            rd_data <= mem[rd_ptr_n];
      end
   end

endmodule

// File: rtl/bayer_quad_demosaic.sv
// rtl/bayer_quad_demosaic.sv - 2x2 Bayer quad to RGB with crop window; optional stats via BAYER_QUAD_STATS_EN
module bayer_quad_demosaic
   import debayer_pkg::*;
#(
   parameter int PIXEL_W    = PIXEL_W_DEF,
   parameter int HSIZE_MAX  = HSIZE_MAX_DEF,
   parameter int X_W        = X_W_DEF,
   parameter int Y_W        = Y_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           bayer_pattern,
   input  logic [X_W-1:0]       x_offset,
   input  logic [Y_W-1:0]       y_offset,
   input  logic [X_W-1:0]       x_size,
   input  logic [Y_W-1:0]       y_size,
   input  logic [PIXEL_W-1:0]   pixel_data,
   input  logic                 pixel_valid,
   input  logic                 lv,
   input  logic                 fv,
   output logic [3*PIXEL_W-1:0] rgb_data,
   output logic                 rgb_valid,
   input  logic                 rgb_ready,
   output logic                 rgb_eol,
   output logic                 rgb_eof,
`ifdef BAYER_QUAD_STATS_EN
   output logic [PIXEL_W+19:0]  sum_r,
   output logic [PIXEL_W+19:0]  sum_g,
   output logic [PIXEL_W+19:0]  sum_b,
   output logic                 stats_valid,
`endif
   output logic                 overflow
);

   localparam int LB_DEPTH = (HSIZE_MAX + 1) / 2;
   localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam int FW       = 3 * PIXEL_W + 2;
   localparam logic [X_W:0] COL_LIMIT = (X_W+1)'(HSIZE_MAX);

   function automatic logic [PIXEL_W-1:0] avg(input logic [PIXEL_W-1:0] x,
                                              input logic [PIXEL_W-1:0] y);
      logic [PIXEL_W:0] s;
      s = {1'b0, x} + {1'b0, y};
      return s[PIXEL_W:1];
   endfunction

   logic                 fv_d, lv_d, frame_active;
   bayer_pattern_e       pattern;
   logic [X_W-1:0]       xo_q, xs_q;
   logic [Y_W-1:0]       yo_q, ys_q;
   logic [X_W-1:0]       col;
   logic [Y_W-1:0]       line;
   logic [PIXEL_W-1:0]   e_hold, p_hold;
   logic [2*PIXEL_W-1:0] linebuf [LB_DEPTH];
   logic [2*PIXEL_W-1:0] lb_rd;
   logic [LB_AW-1:0]     lb_addr;

   logic fv_rise, fv_fall, lv_fall, in_frame, accept;
   logic lb_we, lb_re, quad_ev;

   assign fv_rise  = fv & ~fv_d;
   assign fv_fall  = ~fv & fv_d & frame_active;
   assign lv_fall  = lv_d & ~lv;
   // Input only counts inside a frame whose start was actually observed.
   assign in_frame = fv & (frame_active | fv_rise);
   assign accept   = in_frame & lv & pixel_valid & ({1'b0, col} < COL_LIMIT);
   assign lb_addr  = LB_AW'(col >> 1);
   assign lb_we    = accept & ~line[0] & col[0];
   assign lb_re    = accept & line[0] & ~col[0];
   assign quad_ev  = accept & line[0] & col[0];

   // Crop window test on the quad's top-left corner, one bit wider so sums never wrap.
   logic [X_W:0] qx, x_lo, x_hi;
   logic [Y_W:0] qy, y_lo, y_hi;
   logic         in_x, in_y, at_eol, at_last_row;

   assign qx          = {1'b0, col[X_W-1:1], 1'b0};
   assign x_lo        = {1'b0, xo_q};
   assign x_hi        = {1'b0, xo_q} + {1'b0, xs_q};
   assign qy          = {1'b0, line[Y_W-1:1], 1'b0};
   assign y_lo        = {1'b0, yo_q};
   assign y_hi        = {1'b0, yo_q} + {1'b0, ys_q};
   assign in_x        = (qx >= x_lo) && (qx < x_hi);
   assign in_y        = (qy >= y_lo) && (qy < y_hi);
   assign at_eol      = ((qx + (X_W+1)'(2)) == x_hi);
   assign at_last_row = ((qy + (Y_W+1)'(2)) == y_hi);

   // Frame/line tracking, configuration latch at frame start and pixel holding registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fv_d         <= 1'b1;   // a frame already running at reset release is not a new start
         lv_d         <= 1'b0;
         frame_active <= 1'b0;
         pattern      <= RGGB;
         xo_q         <= '0;
         xs_q         <= '0;
         yo_q         <= '0;
         ys_q         <= '0;
         col          <= '0;
         line         <= '0;
         e_hold       <= '0;
         p_hold       <= '0;
      end else begin
         fv_d <= fv;
         lv_d <= lv;
         if (fv_rise) begin
            frame_active <= 1'b1;
            pattern      <= bayer_pattern_e'(bayer_pattern);
            xo_q         <= x_offset;
            xs_q         <= x_size;
            yo_q         <= y_offset;
            ys_q         <= y_size;
         end else if (fv_fall) begin
            frame_active <= 1'b0;
         end
         if (!in_frame) begin
            col    <= '0;
            line   <= '0;
            p_hold <= '0;
         end else if (lv_fall) begin
            col    <= '0;
            line   <= line + 1'b1;
            p_hold <= '0;
         end else if (accept) begin
            col <= col + 1'b1;
            if (!col[0] && !line[0]) e_hold <= pixel_data;
            if (!col[0] &&  line[0]) p_hold <= pixel_data;
         end
      end
   end

   // Line buffer holds even-line pixel pairs; the pair is fetched at the odd line's even pixel.
   always_ff @(posedge clk) begin
      if (lb_we) linebuf[lb_addr] <= {e_hold, pixel_data};
      if (lb_re) lb_rd <= linebuf[lb_addr];
   end

   logic               s1_valid, s1_eol, s1_eof;
   logic [PIXEL_W-1:0] q_a, q_b, q_c, q_d;

   // Stage 1: capture the formed quad and its crop/position flags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_eol   <= 1'b0;
         s1_eof   <= 1'b0;
         q_a      <= '0;
         q_b      <= '0;
         q_c      <= '0;
         q_d      <= '0;
      end else begin
         s1_valid <= quad_ev & in_x & in_y;
         s1_eol   <= at_eol;
         s1_eof   <= at_eol & at_last_row;
         if (quad_ev) begin
            q_a <= lb_rd[2*PIXEL_W-1:PIXEL_W];
            q_b <= lb_rd[PIXEL_W-1:0];
            q_c <= p_hold;
            q_d <= pixel_data;
         end
      end
   end

   logic [PIXEL_W-1:0] ch_r, ch_g, ch_b;

   // Channel selection by the frame's Bayer phase.
   always_comb begin
      ch_r = q_a;
      ch_g = avg(q_b, q_c);
      ch_b = q_d;
      case (pattern)
         RGGB: begin ch_r = q_a; ch_g = avg(q_b, q_c); ch_b = q_d; end
         GRBG: begin ch_r = q_b; ch_g = avg(q_a, q_d); ch_b = q_c; end
         GBRG: begin ch_r = q_c; ch_g = avg(q_a, q_d); ch_b = q_b; end
         BGGR: begin ch_r = q_d; ch_g = avg(q_b, q_c); ch_b = q_a; end
         default: begin ch_r = q_a; ch_g = avg(q_b, q_c); ch_b = q_d; end
      endcase
   end

   logic                 s2_valid, s2_eol, s2_eof;
   logic [3*PIXEL_W-1:0] s2_rgb;

   // Stage 2: registered RGB word ready for the FIFO.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s2_valid <= 1'b0;
         s2_eol   <= 1'b0;
         s2_eof   <= 1'b0;
         s2_rgb   <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_eol   <= s1_eol;
         s2_eof   <= s1_eof;
         s2_rgb   <= {ch_r, ch_g, ch_b};
      end
   end

   logic [FW-1:0] fifo_q;
   logic          fifo_full, fifo_empty, pop, drop;

   assign pop  = rgb_ready & ~fifo_empty;
   assign drop = s2_valid & fifo_full & ~pop;

   debayer_out_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (s2_valid),
      .wr_data ({s2_eof, s2_eol, s2_rgb}),
      .rd_en   (rgb_ready),
      .rd_data (fifo_q),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign rgb_valid = ~fifo_empty;
   assign rgb_data  = fifo_q[3*PIXEL_W-1:0];
   assign rgb_eol   = fifo_q[3*PIXEL_W];
   assign rgb_eof   = fifo_q[3*PIXEL_W+1];

   // Sticky drop indicator, rearmed at each frame start.
   always_ff @(posedge clk) begin
      if (!reset_n)
         overflow <= 1'b0;
      else if (fv_rise)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
   end

`ifdef BAYER_QUAD_STATS_EN
   logic [PIXEL_W+19:0] acc_r, acc_g, acc_b;
   logic [PIXEL_W+19:0] add_r, add_g, add_b;
   logic                push_ok;

   assign push_ok = s2_valid & ~drop;
   assign add_r   = push_ok ? (PIXEL_W+20)'(s2_rgb[3*PIXEL_W-1:2*PIXEL_W]) : '0;
   assign add_g   = push_ok ? (PIXEL_W+20)'(s2_rgb[2*PIXEL_W-1:PIXEL_W])   : '0;
   assign add_b   = push_ok ? (PIXEL_W+20)'(s2_rgb[PIXEL_W-1:0])           : '0;

   // Per-frame channel totals of queued quads, published at frame end.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_r       <= '0;
         acc_g       <= '0;
         acc_b       <= '0;
         sum_r       <= '0;
         sum_g       <= '0;
         sum_b       <= '0;
         stats_valid <= 1'b0;
      end else begin
         stats_valid <= 1'b0;
         if (fv_fall) begin
            sum_r       <= acc_r + add_r;
            sum_g       <= acc_g + add_g;
            sum_b       <= acc_b + add_b;
            stats_valid <= 1'b1;
            acc_r       <= '0;
            acc_g       <= '0;
            acc_b       <= '0;
         end else begin
            acc_r <= acc_r + add_r;
            acc_g <= acc_g + add_g;
            acc_b <= acc_b + add_b;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bayer_quad_demosaic.sv
// tb/tb_bayer_quad_demosaic.sv - directed self-checking bench for bayer_quad_demosaic
module tb_bayer_quad_demosaic;
   import debayer_pkg::*;

   localparam int PW = 10;
   localparam int XW = 11;
   localparam int YW = 10;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    bayer_pattern;
   logic [XW-1:0] x_offset, x_size;
   logic [YW-1:0] y_offset, y_size;
   logic [PW-1:0] pixel_data;
   logic          pixel_valid, lv, fv;
   logic [3*PW-1:0] rgb_data;
   logic          rgb_valid, rgb_ready, rgb_eol, rgb_eof, overflow;
`ifdef BAYER_QUAD_STATS_EN
   logic [PW+19:0] sum_r, sum_g, sum_b;
   logic           stats_valid;
   int             stats_pulses = 0;
   logic [PW+19:0] last_r, last_g, last_b;
`endif

   always #5 clk = ~clk;

   bayer_quad_demosaic dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bayer_pattern (bayer_pattern),
      .x_offset      (x_offset),
      .y_offset      (y_offset),
      .x_size        (x_size),
      .y_size        (y_size),
      .pixel_data    (pixel_data),
      .pixel_valid   (pixel_valid),
      .lv            (lv),
      .fv            (fv),
      .rgb_data      (rgb_data),
      .rgb_valid     (rgb_valid),
      .rgb_ready     (rgb_ready),
      .rgb_eol       (rgb_eol),
      .rgb_eof       (rgb_eof),
`ifdef BAYER_QUAD_STATS_EN
      .sum_r         (sum_r),
      .sum_g         (sum_g),
      .sum_b         (sum_b),
      .stats_valid   (stats_valid),
`endif
      .overflow      (overflow)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] got_q [$];
   int          pix [0:255];

   // Capture every accepted output word away from the active edge.
   always @(negedge clk) begin
      if (rgb_valid && rgb_ready) got_q.push_back({rgb_eof, rgb_eol, rgb_data});
`ifdef BAYER_QUAD_STATS_EN
      if (stats_valid) begin
         stats_pulses++;
         last_r = sum_r;
         last_g = sum_g;
         last_b = sum_b;
      end
`endif
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input int r, input int g, input int b,
                                        input bit eol, input bit eof);
      rgb_t v;
      v.r = PW'(r);
      v.g = PW'(g);
      v.b = PW'(b);
      return {eof, eol, v};
   endfunction

   function automatic logic [31:0] q_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return 32'hffff_ffff;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_crop(input int xo, input int xs, input int yo, input int ys, input int pat);
      x_offset      = XW'(xo);
      x_size        = XW'(xs);
      y_offset      = YW'(yo);
      y_size        = YW'(ys);
      bayer_pattern = 2'(pat);
   endtask

   task automatic drive_line(input int w, input int l, input int n);
      for (int c = 0; c < n; c++) begin
         lv          = 1'b1;
         pixel_valid = 1'b1;
         pixel_data  = PW'(pix[l*w+c]);
         tick(1);
      end
      pixel_valid = 1'b0;
      lv          = 1'b0;
      tick(2);
   endtask

   task automatic drive_frame(input int w, input int h);
      fv = 1'b1;
      tick(2);
      for (int l = 0; l < h; l++) drive_line(w, l, w);
      tick(4);
      fv = 1'b0;
      tick(4);
   endtask

   initial begin
      reset_n = 1'b0;
      set_crop(0, 0, 0, 0, 0);
      pixel_data  = '0;
      pixel_valid = 1'b0;
      lv          = 1'b0;
      fv          = 1'b0;
      rgb_ready   = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(1);

      check("reset_valid", rgb_valid, 0);
      check("reset_data", rgb_data, 0);
      check("reset_eol", rgb_eol, 0);
      check("reset_eof", rgb_eof, 0);
      check("reset_ovf", overflow, 0);

      // 4x2 RGGB, full crop
      for (int i = 0; i < 8; i++) pix[i] = i + 1;
      set_crop(0, 4, 0, 2, 0);
      rgb_ready = 1'b1;
      got_q.delete();
      drive_frame(4, 2);
      tick(4);
      check("rggb_count", got_q.size(), 2);
      check("rggb_q0", q_at(0), word(1, 3, 6, 0, 0));
      check("rggb_q1", q_at(1), word(3, 5, 8, 1, 1));
`ifdef BAYER_QUAD_STATS_EN
      check("stats_pulses", stats_pulses, 1);
      check("stats_r", last_r, 1 + 3);
      check("stats_g", last_g, 3 + 5);
      check("stats_b", last_b, 6 + 8);
`endif

      // Same data, BGGR
      set_crop(0, 4, 0, 2, 3);
      got_q.delete();
      drive_frame(4, 2);
      tick(4);
      check("bggr_count", got_q.size(), 2);
      check("bggr_q0", q_at(0), word(6, 3, 1, 0, 0));
      check("bggr_q1", q_at(1), word(8, 5, 3, 1, 1));

      // Full-scale green average must not wrap
      pix[0] = 1023; pix[1] = 1023; pix[2] = 1023; pix[3] = 0;
      set_crop(0, 2, 0, 2, 0);
      got_q.delete();
      drive_frame(2, 2);
      tick(4);
      check("max_count", got_q.size(), 1);
      check("max_g", q_at(0) & 32'h000f_fc00, 32'(1023) << 10);
      check("max_q0", q_at(0), word(1023, 1023, 0, 1, 1));

      // 8x4 frame with crop window
      for (int i = 0; i < 32; i++) pix[i] = i + 1;
      set_crop(2, 4, 2, 2, 0);
      got_q.delete();
      drive_frame(8, 4);
      tick(4);
      check("crop_count", got_q.size(), 2);
      check("crop_q0", q_at(0), word(19, 23, 28, 0, 0));
      check("crop_q1", q_at(1), word(21, 25, 30, 1, 1));

      // Backpressure: 40 quads into an 8-deep FIFO
      for (int c = 0; c < 80; c++) begin
         pix[c]      = c;
         pix[80 + c] = 100 + c;
      end
      set_crop(0, 80, 0, 2, 0);
      rgb_ready = 1'b0;
      got_q.delete();
      drive_frame(80, 2);
      check("bp_none_out", got_q.size(), 0);
      check("bp_valid", rgb_valid, 1);
      check("bp_ovf_set", overflow, 1);
      set_crop(0, 0, 0, 0, 0);
      fv = 1'b1;
      tick(2);
      check("bp_ovf_clr", overflow, 0);
      rgb_ready = 1'b1;
      tick(12);
      check("bp_count", got_q.size(), 8);
      for (int k = 0; k < 8; k++)
         check($sformatf("bp_q%0d", k), q_at(k), word(2*k, 2*k + 50, 2*k + 101, 0, 0));
      fv = 1'b0;
      tick(4);

      // Reset in the middle of a line
      for (int i = 0; i < 16; i++) pix[i] = i + 1;
      set_crop(0, 4, 0, 4, 0);
      rgb_ready = 1'b0;
      got_q.delete();
      fv = 1'b1;
      tick(2);
      drive_line(4, 0, 4);
      drive_line(4, 1, 4);
      tick(4);
      check("rst_pre_valid", rgb_valid, 1);
      for (int c = 0; c < 2; c++) begin
         lv = 1'b1; pixel_valid = 1'b1; pixel_data = PW'(pix[8 + c]);
         tick(1);
      end
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      check("rst_valid", rgb_valid, 0);
      check("rst_data", rgb_data, 0);
      for (int c = 2; c < 4; c++) begin
         pixel_data = PW'(pix[8 + c]);
         tick(1);
      end
      pixel_valid = 1'b0; lv = 1'b0;
      tick(2);
      drive_line(4, 3, 4);
      rgb_ready = 1'b1;
      tick(10);
      check("rst_no_output", got_q.size(), 0);
      fv = 1'b0;
      tick(3);
      for (int i = 0; i < 8; i++) pix[i] = i + 1;
      set_crop(0, 4, 0, 2, 0);
      drive_frame(4, 2);
      tick(4);
      check("rst_resume_count", got_q.size(), 2);
      check("rst_resume_q1", q_at(1), word(3, 5, 8, 1, 1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
